// File: rtl/axi_master_cpu.sv
`default_nettype none
// ============================================================================
//  Module   : axi_master_cpu
//  Purpose  : Single-beat AXI4 master bridge. Turns one CPU load/store into
//             one AR/R or AW/W/B transaction (LEN=0, SIZE=word, INCR) and
//             holds the CPU busy until the response returns.
//  Revision : 1.0 - initial release
// ============================================================================
module axi_master_cpu #(
  parameter logic [3:0] MASTER_ID = 4'd0
) (
  input  logic        ACLK,
  input  logic        ARESET,
  // CPU side
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [3:0]  cpu_wstrb,
  output logic        cpu_busy,
  output logic        cpu_done,
  output logic [31:0] cpu_rdata,
  output logic        cpu_err,
  // AXI write address
  output logic [3:0]  AWID,
  output logic [31:0] AWADDR,
  output logic [3:0]  AWLEN,
  output logic [2:0]  AWSIZE,
  output logic [1:0]  AWBURST,
  output logic        AWVALID,
  input  logic        AWREADY,
  // AXI write data
  output logic [31:0] WDATA,
  output logic [3:0]  WSTRB,
  output logic        WLAST,
  output logic        WVALID,
  input  logic        WREADY,
  // AXI write response
  input  logic [3:0]  BID,
  input  logic [1:0]  BRESP,
  input  logic        BVALID,
  output logic        BREADY,
  // AXI read address
  output logic [3:0]  ARID,
  output logic [31:0] ARADDR,
  output logic [3:0]  ARLEN,
  output logic [2:0]  ARSIZE,
  output logic [1:0]  ARBURST,
  output logic        ARVALID,
  input  logic        ARREADY,
  // AXI read data
  input  logic [3:0]  RID,
  input  logic [31:0] RDATA,
  input  logic [1:0]  RRESP,
  input  logic        RLAST,
  input  logic        RVALID,
  output logic        RREADY
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_AR   = 3'd1,
    S_R    = 3'd2,
    S_AW   = 3'd3,
    S_W    = 3'd4,
    S_B    = 3'd5,
    S_DONE = 3'd6
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q,  addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q,   err_d;

  // State and latched payload registers; reset aborts any transaction in flight.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q <= S_IDLE;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      wstrb_q <= 4'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic; payload is only captured in IDLE so it stays stable
  // for the whole time any VALID is high.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (cpu_req) begin
          addr_d  = cpu_addr;
          wdata_d = cpu_wdata;
          wstrb_d = cpu_wstrb;
          err_d   = 1'b0;
          state_d = cpu_we ? S_AW : S_AR;
        end
      end
      S_AR: if (ARREADY) state_d = S_R;
      S_R: begin
        if (RVALID) begin
          rdata_d = RDATA;
          err_d   = (RRESP != 2'b00) | (RID != MASTER_ID) | (RLAST != 1'b1);
          state_d = S_DONE;
        end
      end
      // Data follows the accepted address; slaves only raise WREADY afterwards.
      S_AW: if (AWREADY) state_d = S_W;
      S_W:  if (WREADY)  state_d = S_B;
      S_B: begin
        if (BVALID) begin
          err_d   = (BRESP != 2'b00) | (BID != MASTER_ID);
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake strobes decode from the state register only.
  assign ARVALID = (state_q == S_AR);
  assign RREADY  = (state_q == S_R);
  assign AWVALID = (state_q == S_AW);
  assign WVALID  = (state_q == S_W);
  assign WLAST   = (state_q == S_W);
  assign BREADY  = (state_q == S_B);

  assign cpu_busy  = (state_q != S_IDLE);
  assign cpu_done  = (state_q == S_DONE);
  assign cpu_rdata = rdata_q;
  assign cpu_err   = err_q;

  assign AWID    = MASTER_ID;
  assign ARID    = MASTER_ID;
  assign AWADDR  = addr_q;
  assign ARADDR  = addr_q;
  assign AWLEN   = 4'd0;
  assign ARLEN   = 4'd0;
  assign AWSIZE  = 3'b010;
  assign ARSIZE  = 3'b010;
  assign AWBURST = 2'b01;
  assign ARBURST = 2'b01;
  assign WDATA   = wdata_q;
  assign WSTRB   = wstrb_q;

endmodule
`default_nettype wire

// File: doc/axi_master_cpu.md
# axi_master_cpu

Single-beat AXI4 master bridge between the CPU memory port (instruction-fetch or data side) and the AXI interconnect; it sits directly upstream of the interconnect that feeds the instruction-memory and data-memory slave wrappers. It converts one CPU load or store request into one AR/R or AW/W/B transaction (LEN=0, SIZE=word, INCR), holds the CPU busy until the response returns, and reports read data and error status. One transaction is outstanding at a time.

## Interface
- MASTER_ID, default 4'd0: value driven on ARID/AWID; expected on RID/BID.
- ACLK  in  1  clock; all logic on rising edge.
- ARESET  in  1  synchronous, active-high reset.
- cpu_req  in  1  request strobe; sampled only in IDLE.
- cpu_we  in  1  1 = store, 0 = load.
- cpu_addr  in  32  byte address, passed unchanged to ARADDR/AWADDR.
- cpu_wdata  in  32  store data.
- cpu_wstrb  in  4  active-high byte enables, driven on WSTRB.
- cpu_busy  out  1  high whenever state != IDLE.
- cpu_done  out  1  one-cycle completion pulse.
- cpu_rdata  out  32  load data; valid while cpu_done=1, held afterwards.
- cpu_err  out  1  response error flag; valid while cpu_done=1.
- AWID/ARID out 4; AWADDR/ARADDR out 32; AWLEN/ARLEN out 4; AWSIZE/ARSIZE out 3; AWBURST/ARBURST out 2; AWVALID/ARVALID out 1; AWREADY/ARREADY in 1.
- WDATA out 32; WSTRB out 4; WLAST out 1; WVALID out 1; WREADY in 1.
- BID in 4; BRESP in 2; BVALID in 1; BREADY out 1.
- RID in 4; RDATA in 32; RRESP in 2; RLAST in 1; RVALID in 1; RREADY out 1.

## Operation
- States: IDLE, AR, R, AW, W, B, DONE.
- IDLE: when cpu_req=1, latch addr, wdata, wstrb, we; go to AW if we=1, else AR.
- AR: ARVALID=1; on ARREADY go to R.
- R: RREADY=1; on RVALID, capture RDATA into cpu_rdata and set err = (RRESP!=2'b00) | (RID!=MASTER_ID) | (RLAST!=1); go to DONE.
- AW: AWVALID=1; on AWREADY go to W.
- W: WVALID=1, WLAST=1; on WREADY go to B.
- B: BREADY=1; on BVALID set err = (BRESP!=2'b00) | (BID!=MASTER_ID); go to DONE.
- DONE: cpu_done=1; go to IDLE unconditionally. cpu_req is not sampled in DONE.
- Constant fields: xLEN=4'd0, xSIZE=3'b010, xBURST=2'b01; IDs are MASTER_ID.
- VALID/READY outputs decode from the state register only; payload comes from latched registers. Payload is stable while VALID=1 (AXI rule: VALID is never withdrawn before its handshake).
- W is issued only after AW is accepted, because downstream slaves raise WREADY only after the address phase.
- Requests in any state other than IDLE are ignored; the CPU holds cpu_req/cpu_addr until cpu_done.

## Timing
- Reset (ARESET=1 at an edge): state goes to IDLE; all VALID and READY outputs 0; cpu_busy=0, cpu_done=0, cpu_err=0, cpu_rdata=0; latched addr, wdata, wstrb = 0.
- Reset mid-transaction: abort at that edge with no completion pulse. Any partial handshake is dropped.
- Read latency with zero-wait slave: req at edge 0 → AR (ARVALID) cycle 1 → R cycle 2 → DONE cycle 3 (cpu_done, cpu_rdata). Minimum is 3 cycles from request to done, plus 1 per slave wait cycle in each phase.
- Write latency with zero-wait slave: AW cycle 1, W cycle 2, B cycle 3, DONE cycle 4.
- Back-to-back: a new request is accepted on the edge after DONE, so the minimum read period is 4 cycles.
- cpu_busy rises the cycle after acceptance and falls when the state returns to IDLE. It is also high during DONE.
- RVALID or BVALID asserted outside the R or B state is ignored: no capture, READY stays 0.

## Test plan
- Read, zero-wait slave: req=1, we=0, addr=32'h0000_0040; slave returns RDATA=32'hDEADBEEF, RRESP=0, RLAST=1 → ARVALID in cycle 1 with ARADDR=0x40 and ARLEN=0; cpu_done in cycle 3 with rdata=DEADBEEF and err=0.
- Write with stalls: addr=0x0000_1000, wdata=0x12345678, wstrb=4'b0011; AWREADY delayed 2 cycles, WREADY delayed 1 cycle → AWVALID held 3 cycles with stable payload; WVALID/WLAST=1 only after AW is accepted; WSTRB=0011; cpu_done 7 cycles after req.
- Error response: read returning RRESP=2'b11 → cpu_err=1 during cpu_done; then a write with BID=4'd1 while MASTER_ID=0 → cpu_err=1.
- Ignored request: assert a second cpu_req with a different address during R → no new ARVALID until after DONE, and ARADDR for the first transaction stays unchanged.
- Reset mid-write: assert ARESET while in W with WVALID=1 → next cycle WVALID=0, cpu_busy=0, no cpu_done; a following read completes normally.
